// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit collection, greedy one-coin-per-cycle change payout.
// Optional per-item stock counters are enabled with `define STOCK_COUNT_EN.
module vending_machine_multi #(
  parameter int                    N_ITEMS     = 4,
  parameter int                    MW          = 8,
  parameter logic [MW-1:0]         COIN0_VAL   = 1,
  parameter logic [MW-1:0]         COIN1_VAL   = 2,
  parameter logic [MW-1:0]         COIN2_VAL   = 5,
  parameter logic [N_ITEMS*MW-1:0] PRICE_TABLE = {8'd12, 8'd7, 8'd5, 8'd3},
  parameter int                    STOCK_INIT  = 4,
  localparam int                   SEL_W       = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       i_coin,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_confirm,
  input  logic             i_cancel,
  input  logic             i_finish,
  output logic [MW-1:0]    o_price,
  output logic [MW-1:0]    o_money,
  output logic [MW-1:0]    o_change,
  output logic [2:0]       o_change_coin,
  output logic             o_ready,
  output logic             o_goods,
  output logic             o_coin_reject,
  output logic             o_sold_out
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_PAYOUT  = 2'd3;

  if (COIN0_VAL == '0 || STOCK_INIT < 0) begin : g_cfg_check
    $error("vending_machine_multi: COIN0_VAL must be >= 1 and STOCK_INIT >= 0");
  end

  logic [1:0]    state_q, state_d;
  logic [MW-1:0] money_q, money_d;
  logic [MW-1:0] change_q, change_d;
  logic [MW-1:0] price_q, price;
  logic          reject_q, reject_d;
  logic [MW-1:0] coin_val;
  logic [MW:0]   coin_sum;
  logic [2:0]    pay_coin;
  logic          sel_valid, coin_onehot, coin_fits, coin_taken, buy_ok, sold_out;

  always_comb begin
    price     = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (i_sel == SEL_W'(i)) begin
        price     = PRICE_TABLE[i*MW +: MW];
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    coin_onehot = 1'b1;
    case (i_coin)
      3'b001:  coin_val = COIN0_VAL;
      3'b010:  coin_val = COIN1_VAL;
      3'b100:  coin_val = COIN2_VAL;
      default: begin
        coin_val    = '0;
        coin_onehot = 1'b0;
      end
    endcase
  end

  // Carry out of the sum means the credit would exceed the register range.
  assign coin_sum  = {1'b0, money_q} + {1'b0, coin_val};
  assign coin_fits = coin_onehot && !coin_sum[MW];
  assign buy_ok    = i_confirm && sel_valid && !sold_out && (money_q >= price);

  always_comb begin
    state_d    = state_q;
    money_d    = money_q;
    change_d   = change_q;
    coin_taken = 1'b0;
    pay_coin   = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (coin_fits) begin
          money_d    = coin_sum[MW-1:0];
          coin_taken = 1'b1;
          state_d    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_cancel) begin
          change_d = money_q;
          money_d  = '0;
          state_d  = S_PAYOUT;
        end else if (buy_ok) begin
          change_d = money_q - price;
          money_d  = '0;
          state_d  = S_VEND;
        end else if (coin_fits) begin
          money_d    = coin_sum[MW-1:0];
          coin_taken = 1'b1;
        end
      end
      S_VEND: begin
        if (i_finish) state_d = S_PAYOUT;
      end
      S_PAYOUT: begin
        if (change_q >= COIN2_VAL) begin
          pay_coin = 3'b100;
          change_d = change_q - COIN2_VAL;
        end else if (change_q >= COIN1_VAL) begin
          pay_coin = 3'b010;
          change_d = change_q - COIN1_VAL;
        end else if (change_q >= COIN0_VAL) begin
          pay_coin = 3'b001;
          change_d = change_q - COIN0_VAL;
        end else begin
          change_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reject_d = (i_coin != 3'b000) && !coin_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      money_q  <= '0;
      change_q <= '0;
      price_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      money_q  <= money_d;
      change_q <= change_d;
      price_q  <= price;
      reject_q <= reject_d;
    end
  end

`ifdef STOCK_COUNT_EN
  logic [MW-1:0] stock_q [N_ITEMS];
  logic          vend_start;

  assign vend_start = (state_q == S_COLLECT) && !i_cancel && buy_ok;

  always_comb begin
    sold_out = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (i_sel == SEL_W'(i)) sold_out = (stock_q[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= MW'(STOCK_INIT);
    end else if (vend_start) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (i_sel == SEL_W'(i)) stock_q[i] <= stock_q[i] - MW'(1);
      end
    end
  end
`else
  assign sold_out = 1'b0;
`endif

  assign o_price       = price_q;
  assign o_money       = money_q;
  assign o_change      = change_q;
  assign o_change_coin = pay_coin;
  assign o_ready       = (state_q == S_IDLE);
  assign o_goods       = (state_q == S_VEND);
  assign o_coin_reject = reject_q;
  assign o_sold_out    = sold_out;
endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised successor to the single-product vending controller. It supports N_ITEMS selectable products with a per-item price table and configurable coin denominations. It adds coin rejection on overflow and returns change one coin per cycle, largest denomination first. It sits between the coin acceptor and front-panel logic and the dispenser and change-hopper drivers.

Parameters:
N_ITEMS, 4, number of products; SEL_W = max(1, $clog2(N_ITEMS)) is a derived localparam
MW, 8, width of money, price and change values
COIN0_VAL, 1, value of coin slot 0 (smallest, must be >= 1)
COIN1_VAL, 2, value of coin slot 1
COIN2_VAL, 5, value of coin slot 2 (largest)
PRICE_TABLE, {8'd12,8'd7,8'd5,8'd3}, packed N_ITEMS*MW prices; item 0 in the LSBs
STOCK_INIT, 4, initial stock per item (used only with STOCK_COUNT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
i_coin  input  3  coin-insert pulses, one-hot, one cycle per coin
i_sel  input  SEL_W  product select
i_confirm  input  1  purchase request (level)
i_cancel  input  1  abort and refund (level)
i_finish  input  1  customer has taken the goods
o_price  output  MW  registered price of i_sel
o_money  output  MW  current credit
o_change  output  MW  change still to be paid out
o_change_coin  output  3  one-hot payout pulse, one coin per cycle
o_ready  output  1  high in IDLE
o_goods  output  1  dispense, held high in VEND
o_coin_reject  output  1  one-cycle pulse when a coin is refused
o_sold_out  output  1  selected item has zero stock (0 when the feature is off)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0 except o_ready=1. Reset mid-operation discards all credit and change.
- o_price updates every cycle from PRICE_TABLE[i_sel]. If i_sel >= N_ITEMS, o_price=0 and confirm is ignored.
- Coin handling, valid in IDLE and COLLECT: a one-hot i_coin adds its value to o_money on the next edge.
- A coin is rejected (o_coin_reject pulses, credit unchanged) when: i_coin is not one-hot; money+value exceeds 2^MW-1; or it arrives in a cycle where confirm or cancel is acted on. i_coin in VEND or PAYOUT is also rejected.
- States:
  - IDLE: an accepted coin moves to COLLECT.
  - COLLECT: priority is cancel > confirm > coin.
    - cancel: o_change=o_money, o_money=0, go to PAYOUT, no goods.
    - confirm with valid sel and o_money >= price: latch sel, o_change=o_money-price, o_money=0, go to VEND.
    - confirm with o_money < price: ignored, stay in COLLECT.
  - VEND: o_goods=1 until i_finish=1. In the cycle after that, go to PAYOUT. i_cancel is ignored here.
  - PAYOUT: one coin per cycle.
    - o_change >= COIN2_VAL: pulse coin2 and subtract COIN2_VAL.
    - else if o_change >= COIN1_VAL: pulse coin1.
    - else if o_change >= COIN0_VAL: pulse coin0.
    - If o_change=0, or a nonzero residual < COIN0_VAL (which is cleared), go to IDLE with no pulse.
- Latency: confirm to o_goods is 1 cycle. Change of C pays out over exactly as many cycles as greedy coins, plus 1 cycle to return to IDLE.
- Arithmetic is unsigned MW bits, with no wrap: overflow is prevented by rejection.

Optional Feature:
Macro STOCK_COUNT_EN.
- Defined:
  - Each item keeps a stock counter, reset to STOCK_INIT and decremented on entry to VEND.
  - o_sold_out = (stock[i_sel]==0).
  - confirm on a sold-out item is ignored, stays in COLLECT, and keeps the credit.
- Undefined: no counters; o_sold_out tied to 0; stock is unlimited.

Test Plan:
- sel=1 (price 5); coins 1,2,5 give o_money=8. Confirm: o_goods=1, o_money=0, o_change=3. Finish: o_change_coin 010 then 001, o_change=0, then o_ready=1.
- sel=2; coins 1,2,2 give o_money=5. Cancel: single coin2 pulse, o_goods stays 0, back to IDLE.
- sel=3 (price 12); o_money=5. Confirm: stays COLLECT, o_goods=0, o_money=5. Add 5,2: confirm succeeds, o_change=0, no payout pulses.
- 51 coin2 pulses give o_money=255. The next coin1 gives o_coin_reject=1 and o_money=255. i_coin=3'b011 is also rejected.
- Assert reset low mid-PAYOUT with o_change=7: outputs clear immediately, and after release o_ready=1, o_money=0.
- STOCK_COUNT_EN, STOCK_INIT=1: buy item 0 once, then o_sold_out=1 for sel=0. A second confirm with 3 credit is ignored and o_money stays 3.
